benes_cfg_ctrl: RTL and testbench
=================================

Name: benes_cfg_ctrl

Overview:
- Configuration controller for a Benes interconnect built from 2x2 bar/cross switch cells. Bit value per cell: 0 = bar, 1 = cross.
- Holds NUM_CFG preloaded permutation entries, each giving the full switch_set vector.
- On request, drives the selected entry onto every switch cell's switch_set input. Waits a settle interval, then reports the network ready.
- Sits between the host/config bus and the switch array; the data path does not pass through this block.

Parameters:
- N, 8, network port count; power of two, >= 4.
- NUM_CFG, 4, number of stored permutation entries; power of two, >= 2.
- CFG_WORD, 8, config write-bus width in bits.
- SETTLE_CYC, 2, cycles to wait after switch_set update before net_ready; 0 allowed.
- Derived, not overridable:
  - LOGN = clog2(N).
  - NUM_SW = (N/2)*(2*LOGN-1); 20 for N=8.
  - WPC = ceil(NUM_SW/CFG_WORD); 3 for defaults.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- cfg_wr_en  in  1  config word write strobe.
- cfg_wr_sel  in  clog2(NUM_CFG)  target entry.
- cfg_wr_word  in  max(1,clog2(WPC))  word index within entry.
- cfg_wr_data  in  CFG_WORD  config data.
- cfg_wr_ready  out  1  write accepted this cycle when high.
- sel_req_valid  in  1  request to apply an entry.
- sel_req_idx  in  clog2(NUM_CFG)  entry to apply.
- sel_req_ready  out  1  request accepted when valid & ready.
- sel_err  out  1  one-cycle pulse: accepted request named an entry not fully loaded.
- switch_set  out  NUM_SW  to switch cells; bit k = stage k/(N/2), cell k%(N/2).
- cfg_active_idx  out  clog2(NUM_CFG)  entry currently applied.
- net_ready  out  1  network configured and settled.
- busy  out  1  high in APPLY or SETTLE.

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset values:
  - state IDLE.
  - switch_set = 0 (all bar, identity).
  - cfg_active_idx = 0.
  - net_ready, busy and sel_err = 0.
  - All entry word-written masks cleared.
  - Memory contents are not reset.
- Config memory:
  - NUM_CFG x WPC words of CFG_WORD bits.
  - Word w holds switch bits [w*CFG_WORD +: CFG_WORD]. Bits beyond NUM_SW in the last word are ignored.
  - A write occurs when cfg_wr_en & cfg_wr_ready. It stores the data and sets mask bit [sel][word].
  - cfg_wr_word >= WPC: write dropped, no mask change.
  - An entry is valid when all WPC mask bits are set. Rewriting a valid entry keeps it valid.
- cfg_wr_ready = 0 only in APPLY; 1 otherwise, including during reset deassertion.
- FSM states: IDLE, APPLY, SETTLE, READY.
  - sel_req_ready = 1 in IDLE and READY, 0 in APPLY and SETTLE.
  - Accept at cycle t, valid entry:
    - t+1: APPLY. switch_set and cfg_active_idx load at the end of t+1.
    - From t+2: SETTLE for SETTLE_CYC cycles.
    - READY with net_ready = 1 from cycle t+2+SETTLE_CYC.
    - SETTLE_CYC = 0: APPLY goes directly to READY, so net_ready is high at t+2.
  - Accept at cycle t, invalid entry:
    - sel_err = 1 at t+1.
    - State, switch_set, cfg_active_idx and net_ready unchanged.
  - Accept in READY: net_ready drops at t+1 and stays low until the new settle completes.
- Hazards:
  - Validity check uses the masks registered before cycle t.
  - The data read in APPLY includes any write committed at cycle t (write-first).
  - A write to the active entry does not alter switch_set until that entry is re-applied.
- Reset asserted mid-APPLY or mid-SETTLE: returns to reset values on the next edge. No partial switch_set is retained.
- switch_set is registered and glitch-free; it changes only at the APPLY edge.

Optional Feature:
- Macro: BENES_CFG_BYPASS_EN.
- When defined:
  - Adds input byp_req (1 bit) and output byp_active (1 bit).
  - byp_req sampled in IDLE/READY takes priority over sel_req_valid. sel_req_ready is 0 in that cycle.
  - Runs APPLY/SETTLE with switch_set = 0. cfg_active_idx is unchanged.
  - byp_active = 1 from the APPLY edge until the next successful sel apply.
  - Reset value of byp_active is 0.
- When undefined: both ports are absent and the logic is not generated.

Test Plan:
- Reset then idle: switch_set = 0, net_ready = 0, sel_req_ready = 1, cfg_wr_ready = 1.
- Write entry 2 words 0..2 = 0xA5, 0x3C, 0x0F; request idx 2 at t:
  - switch_set = 0xF3CA5 visible at t+2.
  - net_ready rises at t+4.
  - cfg_active_idx = 2.
- Write only words 0,1 of entry 1; request idx 1:
  - sel_err pulses at t+1.
  - switch_set, net_ready and cfg_active_idx unchanged.
- From READY on entry 2, request entry 0 (loaded, all 0xFF):
  - net_ready low at t+1.
  - switch_set = 0xFFFFF at t+2.
  - net_ready high at t+4.
  - sel_req_valid held during APPLY/SETTLE is not accepted.
- Write entry 2 word 0 = 0x11 in the same cycle as the request for 2: applied switch_set = 0xF3C11. Assert rst during SETTLE: all outputs return to reset values next cycle.
- With BENES_CFG_BYPASS_EN: in READY on entry 2, assert byp_req and sel_req_valid together:
  - Bypass wins; switch_set = 0, byp_active = 1, cfg_active_idx = 2.
  - A later sel of entry 2 clears byp_active.

Source files
------------

// File: rtl/benes_cfg_ctrl.sv
// Configuration controller for a Benes network of 2x2 bar/cross cells: stores permutation
// entries and applies one to switch_set on request. Optional bypass path: BENES_CFG_BYPASS_EN.
module benes_cfg_ctrl #(
  parameter int N          = 8,
  parameter int NUM_CFG    = 4,
  parameter int CFG_WORD   = 8,
  parameter int SETTLE_CYC = 2,
  localparam int LOGN      = $clog2(N),
  localparam int NUM_SW    = (N / 2) * (2 * LOGN - 1),
  localparam int WPC       = (NUM_SW + CFG_WORD - 1) / CFG_WORD,
  localparam int SEL_W     = $clog2(NUM_CFG),
  localparam int WORD_W    = (WPC > 1) ? $clog2(WPC) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_wr_en,
  input  logic [SEL_W-1:0]    cfg_wr_sel,
  input  logic [WORD_W-1:0]   cfg_wr_word,
  input  logic [CFG_WORD-1:0] cfg_wr_data,
  output logic                cfg_wr_ready,
  input  logic                sel_req_valid,
  input  logic [SEL_W-1:0]    sel_req_idx,
  output logic                sel_req_ready,
  output logic                sel_err,
  output logic [NUM_SW-1:0]   switch_set,
  output logic [SEL_W-1:0]    cfg_active_idx,
  output logic                net_ready,
`ifdef BENES_CFG_BYPASS_EN
  input  logic                byp_req,
  output logic                byp_active,
`endif
  output logic                busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_APPLY  = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam logic [1:0] S_READY  = 2'd3;

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
  localparam logic [WORD_W:0]  WPC_L    = (WORD_W + 1)'(WPC);

  logic [1:0]        state;
  logic [SEL_W-1:0]  pend_idx;
  logic [CNT_W-1:0]  settle_cnt;
  logic [WPC-1:0]    wmask [NUM_CFG];
  logic [NUM_SW-1:0] mem [NUM_CFG];
  logic [NUM_SW-1:0] wr_bit_sel;
  logic [NUM_SW-1:0] wr_bit_data;
  logic [NUM_SW-1:0] entry_bits;
  logic              req_window;
  logic              wr_fire;
`ifdef BENES_CFG_BYPASS_EN
  logic              pend_byp;
`endif

  assign req_window   = (state == S_IDLE) || (state == S_READY);
  assign cfg_wr_ready = (state != S_APPLY);
  assign net_ready    = (state == S_READY);
  assign busy         = (state == S_APPLY) || (state == S_SETTLE);
  assign wr_fire      = cfg_wr_en && cfg_wr_ready && ({1'b0, cfg_wr_word} < WPC_L);
  assign entry_bits   = mem[pend_idx];

`ifdef BENES_CFG_BYPASS_EN
  assign sel_req_ready = req_window && !byp_req;
`else
  assign sel_req_ready = req_window;
`endif

  // Each switch bit k lives in word k/CFG_WORD; padding bits of the last word are never stored.
  for (genvar k = 0; k < NUM_SW; k++) begin : g_wr_map
    assign wr_bit_sel[k]  = (cfg_wr_word == WORD_W'(k / CFG_WORD));
    assign wr_bit_data[k] = cfg_wr_data[k % CFG_WORD];
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[cfg_wr_sel] <= (mem[cfg_wr_sel] & ~wr_bit_sel) | (wr_bit_data & wr_bit_sel);
    end
  end

  // Validity uses masks as registered before the request cycle; APPLY reads memory one
  // cycle later, so a write landing alongside the request is picked up (write-first).
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      switch_set     <= '0;
      cfg_active_idx <= '0;
      sel_err        <= 1'b0;
      pend_idx       <= '0;
      settle_cnt     <= '0;
      for (int i = 0; i < NUM_CFG; i++) wmask[i] <= '0;
`ifdef BENES_CFG_BYPASS_EN
      pend_byp       <= 1'b0;
      byp_active     <= 1'b0;
`endif
    end else begin
      sel_err <= 1'b0;
      if (wr_fire) wmask[cfg_wr_sel][cfg_wr_word] <= 1'b1;
      case (state)
        S_IDLE, S_READY: begin
`ifdef BENES_CFG_BYPASS_EN
          if (byp_req) begin
            state    <= S_APPLY;
            pend_byp <= 1'b1;
          end else if (sel_req_valid) begin
            if (&wmask[sel_req_idx]) begin
              state    <= S_APPLY;
              pend_idx <= sel_req_idx;
              pend_byp <= 1'b0;
            end else begin
              sel_err <= 1'b1;
            end
          end
`else
          if (sel_req_valid) begin
            if (&wmask[sel_req_idx]) begin
              state    <= S_APPLY;
              pend_idx <= sel_req_idx;
            end else begin
              sel_err <= 1'b1;
            end
          end
`endif
        end
        S_APPLY: begin
`ifdef BENES_CFG_BYPASS_EN
          byp_active <= pend_byp;
          if (pend_byp) begin
            switch_set <= '0;
          end else begin
            switch_set     <= entry_bits;
            cfg_active_idx <= pend_idx;
          end
`else
          switch_set     <= entry_bits;
          cfg_active_idx <= pend_idx;
`endif
          settle_cnt <= CNT_INIT;
          state      <= (SETTLE_CYC == 0) ? S_READY : S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_cnt == '0) state <= S_READY;
          else settle_cnt <= settle_cnt - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_benes_cfg_ctrl.sv
// Directed self-checking bench for benes_cfg_ctrl at default parameters (N=8, 4 entries,
// 8-bit words, settle 2); the bypass steps compile in only with BENES_CFG_BYPASS_EN.
module tb_benes_cfg_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_wr_en;
  logic [1:0]  cfg_wr_sel;
  logic [1:0]  cfg_wr_word;
  logic [7:0]  cfg_wr_data;
  logic        cfg_wr_ready;
  logic        sel_req_valid;
  logic [1:0]  sel_req_idx;
  logic        sel_req_ready;
  logic        sel_err;
  logic [19:0] switch_set;
  logic [1:0]  cfg_active_idx;
  logic        net_ready;
  logic        busy;
`ifdef BENES_CFG_BYPASS_EN
  logic        byp_req;
  logic        byp_active;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  benes_cfg_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_wr_en      (cfg_wr_en),
    .cfg_wr_sel     (cfg_wr_sel),
    .cfg_wr_word    (cfg_wr_word),
    .cfg_wr_data    (cfg_wr_data),
    .cfg_wr_ready   (cfg_wr_ready),
    .sel_req_valid  (sel_req_valid),
    .sel_req_idx    (sel_req_idx),
    .sel_req_ready  (sel_req_ready),
    .sel_err        (sel_err),
    .switch_set     (switch_set),
    .cfg_active_idx (cfg_active_idx),
    .net_ready      (net_ready),
`ifdef BENES_CFG_BYPASS_EN
    .byp_req        (byp_req),
    .byp_active     (byp_active),
`endif
    .busy           (busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic wr_en, input logic [1:0] wsel, input logic [1:0] wword,
                               input logic [7:0] wdata, input logic rv, input logic [1:0] ridx);
    cfg_wr_en     = wr_en;
    cfg_wr_sel    = wsel;
    cfg_wr_word   = wword;
    cfg_wr_data   = wdata;
    sel_req_valid = rv;
    sel_req_idx   = ridx;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 2'd0);
  endtask

  task automatic cycle();
    @(negedge clk);
  endtask

  task automatic writeWord(input logic [1:0] wsel, input logic [1:0] wword, input logic [7:0] wdata);
    applyStimulus(1'b1, wsel, wword, wdata, 1'b0, 2'd0);
    cycle();
    idle();
  endtask

  // Presents a request for one cycle and lands mid-cycle t+1.
  task automatic request(input logic [1:0] ridx);
    applyStimulus(1'b0, 2'd0, 2'd0, 8'h00, 1'b1, ridx);
    cycle();
    idle();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired before the sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    idle();
`ifdef BENES_CFG_BYPASS_EN
    byp_req = 1'b0;
`endif
    repeat (2) cycle();
    checkOutput("rst_switch_set", switch_set, 0);
    checkOutput("rst_net_ready", net_ready, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_sel_err", sel_err, 0);
    checkOutput("rst_active_idx", cfg_active_idx, 0);
    checkOutput("rst_sel_req_ready", sel_req_ready, 1);
    checkOutput("rst_cfg_wr_ready", cfg_wr_ready, 1);
    rst = 1'b0;
    cycle();
    checkOutput("idle_sel_req_ready", sel_req_ready, 1);
    checkOutput("idle_cfg_wr_ready", cfg_wr_ready, 1);

    request(2'd0);
    checkOutput("empty_req_sel_err", sel_err, 1);
    checkOutput("empty_req_busy", busy, 0);
    cycle();
    checkOutput("empty_req_sel_err_clear", sel_err, 0);

    writeWord(2'd2, 2'd0, 8'hA5);
    writeWord(2'd2, 2'd1, 8'h3C);
    writeWord(2'd2, 2'd2, 8'h0F);
    writeWord(2'd0, 2'd0, 8'hFF);
    writeWord(2'd0, 2'd1, 8'hFF);
    writeWord(2'd0, 2'd2, 8'hFF);
    writeWord(2'd1, 2'd0, 8'h11);
    writeWord(2'd1, 2'd1, 8'h22);
    writeWord(2'd3, 2'd0, 8'h33);
    writeWord(2'd3, 2'd1, 8'h44);
    writeWord(2'd3, 2'd3, 8'h55);

    request(2'd2);
    checkOutput("e2_t1_busy", busy, 1);
    checkOutput("e2_t1_net_ready", net_ready, 0);
    checkOutput("e2_t1_sel_req_ready", sel_req_ready, 0);
    checkOutput("e2_t1_cfg_wr_ready", cfg_wr_ready, 0);
    checkOutput("e2_t1_switch_set", switch_set, 0);
    cycle();
    checkOutput("e2_t2_switch_set", switch_set, 20'hF3CA5);
    checkOutput("e2_t2_active_idx", cfg_active_idx, 2);
    checkOutput("e2_t2_cfg_wr_ready", cfg_wr_ready, 1);
    checkOutput("e2_t2_net_ready", net_ready, 0);
    cycle();
    checkOutput("e2_t3_net_ready", net_ready, 0);
    checkOutput("e2_t3_busy", busy, 1);
    cycle();
    checkOutput("e2_t4_net_ready", net_ready, 1);
    checkOutput("e2_t4_busy", busy, 0);
    checkOutput("e2_t4_sel_req_ready", sel_req_ready, 1);

`ifdef BENES_CFG_BYPASS_EN
    byp_req = 1'b1;
    applyStimulus(1'b0, 2'd0, 2'd0, 8'h00, 1'b1, 2'd0);
    #1;
    checkOutput("byp_sel_req_ready", sel_req_ready, 0);
    cycle();
    byp_req = 1'b0;
    idle();
    checkOutput("byp_t1_busy", busy, 1);
    cycle();
    checkOutput("byp_t2_switch_set", switch_set, 0);
    checkOutput("byp_t2_byp_active", byp_active, 1);
    checkOutput("byp_t2_active_idx", cfg_active_idx, 2);
    cycle();
    cycle();
    checkOutput("byp_t4_net_ready", net_ready, 1);
    request(2'd2);
    cycle();
    checkOutput("unbyp_t2_switch_set", switch_set, 20'hF3CA5);
    checkOutput("unbyp_t2_byp_active", byp_active, 0);
    cycle();
    cycle();
    checkOutput("unbyp_t4_net_ready", net_ready, 1);
`endif

    request(2'd1);
    checkOutput("e1_partial_sel_err", sel_err, 1);
    checkOutput("e1_partial_net_ready", net_ready, 1);
    checkOutput("e1_partial_switch_set", switch_set, 20'hF3CA5);
    checkOutput("e1_partial_active_idx", cfg_active_idx, 2);
    checkOutput("e1_partial_busy", busy, 0);
    cycle();
    checkOutput("e1_partial_sel_err_clear", sel_err, 0);
    checkOutput("e1_partial_net_ready_hold", net_ready, 1);

    request(2'd3);
    checkOutput("e3_dropped_word_sel_err", sel_err, 1);
    checkOutput("e3_dropped_word_busy", busy, 0);
    cycle();

    request(2'd0);
    checkOutput("e0_t1_net_ready", net_ready, 0);
    checkOutput("e0_t1_sel_req_ready", sel_req_ready, 0);
    checkOutput("e0_t1_cfg_wr_ready", cfg_wr_ready, 0);
    applyStimulus(1'b1, 2'd1, 2'd2, 8'h55, 1'b1, 2'd1);
    cycle();
    checkOutput("e0_t2_switch_set", switch_set, 20'hFFFFF);
    checkOutput("e0_t2_active_idx", cfg_active_idx, 0);
    checkOutput("e0_t2_sel_err", sel_err, 0);
    applyStimulus(1'b0, 2'd0, 2'd0, 8'h00, 1'b1, 2'd1);
    cycle();
    checkOutput("e0_t3_net_ready", net_ready, 0);
    checkOutput("e0_t3_sel_err", sel_err, 0);
    cycle();
    idle();
    checkOutput("e0_t4_net_ready", net_ready, 1);
    checkOutput("e0_t4_sel_err", sel_err, 0);
    cycle();
    checkOutput("e0_t5_net_ready", net_ready, 1);

    request(2'd1);
    checkOutput("apply_write_dropped_sel_err", sel_err, 1);
    cycle();

    applyStimulus(1'b1, 2'd2, 2'd0, 8'h11, 1'b1, 2'd2);
    cycle();
    idle();
    checkOutput("wf_t1_busy", busy, 1);
    cycle();
    checkOutput("wf_t2_switch_set", switch_set, 20'hF3C11);
    checkOutput("wf_t2_active_idx", cfg_active_idx, 2);
    rst = 1'b1;
    cycle();
    checkOutput("midrst_switch_set", switch_set, 0);
    checkOutput("midrst_net_ready", net_ready, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_active_idx", cfg_active_idx, 0);
    checkOutput("midrst_sel_req_ready", sel_req_ready, 1);
    checkOutput("midrst_cfg_wr_ready", cfg_wr_ready, 1);
    rst = 1'b0;
    cycle();

    request(2'd2);
    checkOutput("post_rst_mask_sel_err", sel_err, 1);
    checkOutput("post_rst_mask_busy", busy, 0);
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
